uart_boot_ctrl: RTL and testbench

- Packet-level boot/programming sequencer that sits between the UART byte receive/transmit path and the instruction-memory write port.
- Parses framed host packets from the RX byte stream and writes 32-bit words to instruction memory.
- Holds the CPU stalled during programming. Releases it with a one-cycle CPU reset pulse on a RUN command.
- Answers each packet with a single ACK or NAK byte on the TX byte interface.

---
 rtl/uart_boot_ctrl_pkg.sv | 32 +++
 rtl/uart_boot_ctrl_if.sv | 39 +++
 rtl/uart_boot_ctrl_timeout.sv | 42 ++++
 rtl/uart_boot_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_uart_boot_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_boot_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : boot_pkg
// Description : Shared states, command codes and framing bytes for the UART
//               boot controller.
// Revision    : 1.0 - initial release
// ============================================================================
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_LEN  = 3'd3,
        ST_DATA = 3'd4,
        ST_CHK  = 3'd5,
        ST_RESP = 3'd6,
        ST_RUN  = 3'd7
    } state_e;

    localparam logic [7:0] CMD_WRITE    = 8'h01;
    localparam logic [7:0] CMD_RUN      = 8'h02;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam logic [7:0] ACK_DEFAULT  = 8'h06;
    localparam logic [7:0] NAK_DEFAULT  = 8'h15;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_boot_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_boot_ctrl_if
// Description : Byte stream, response, instruction-memory and CPU control
//               signals of the boot controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_boot_ctrl_if;

    logic        enable;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        tx_ready;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic        imem_WE;
    logic [31:0] imem_A;
    logic [31:0] imem_WD;
    logic        cpu_stall;
    logic        cpu_reset;
    logic        busy;
    logic [7:0]  err_count;

    // Host / system side
    modport master (
        output enable, rx_valid, rx_byte, tx_ready,
        input  tx_valid, tx_byte, imem_WE, imem_A, imem_WD,
        input  cpu_stall, cpu_reset, busy, err_count
    );

    // Boot controller side
    modport slave (
        input  enable, rx_valid, rx_byte, tx_ready,
        output tx_valid, tx_byte, imem_WE, imem_A, imem_WD,
        output cpu_stall, cpu_reset, busy, err_count
    );

endinterface
`default_nettype wire

// File: rtl/uart_boot_ctrl_timeout.sv
`default_nettype none
// ============================================================================
// Module      : boot_timeout
// Description : Reloadable down-counter; expire_o flags the last idle cycle
//               of an enabled window that saw no reload.
// Revision    : 1.0 - initial release
// ============================================================================
module boot_timeout #(
    parameter int unsigned CYCLES = 5_000_000
) (
    input  wire logic CLK,
    input  wire logic reset,
    input  wire logic clear_i,
    input  wire logic en_i,
    output logic      expire_o
);

    logic [31:0] remaining_q;
    logic [31:0] remaining_d;

    always_comb begin
        remaining_d = remaining_q;
        if (clear_i) begin
            remaining_d = CYCLES;
        end else if (en_i && (remaining_q != 32'd0)) begin
            remaining_d = remaining_q - 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            remaining_q <= CYCLES;
        end else begin
            remaining_q <= remaining_d;
        end
    end

    // A reload in the same cycle always beats expiry
    assign expire_o = en_i && !clear_i && (remaining_q == 32'd1);

endmodule
`default_nettype wire

// File: rtl/uart_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_boot_ctrl
// Description : Parses framed host packets from the UART byte stream, writes
//               instruction memory, and releases the CPU on a RUN command.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_boot_ctrl
    import boot_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
    parameter int unsigned MAX_WORDS      = 1024,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT,
    parameter logic [7:0]  ACK_BYTE       = ACK_DEFAULT,
    parameter logic [7:0]  NAK_BYTE       = NAK_DEFAULT
) (
    input  wire logic       CLK,
    input  wire logic       reset,
    uart_boot_ctrl_if.slave bus
);

    state_e      state_q,     state_d;
    logic        tx_valid_q,  tx_valid_d;
    logic [7:0]  tx_byte_q,   tx_byte_d;
    logic        we_q,        we_d;
    logic [31:0] addr_q,      addr_d;
    logic [31:0] wd_q,        wd_d;
    logic        stall_q,     stall_d;
    logic        cpu_rst_q,   cpu_rst_d;
    logic        busy_q,      busy_d;
    logic [7:0]  err_q,       err_d;
    logic [7:0]  chk_q,       chk_d;
    logic        bad_q,       bad_d;
    logic        run_q,       run_d;
    logic        adv_q,       adv_d;
    logic [1:0]  cnt_q,       cnt_d;
    logic [15:0] len_q,       len_d;

    logic        w_window;
    logic        w_sum_window;
    logic        w_expire;
    logic        w_to_clear;
    logic [15:0] w_len;

    assign w_window     = (state_q == ST_CMD)  || (state_q == ST_ADDR) ||
                          (state_q == ST_LEN)  || (state_q == ST_DATA) ||
                          (state_q == ST_CHK);
    assign w_sum_window = w_window && (state_q != ST_CHK);
    assign w_to_clear   = bus.rx_valid || !w_window;
    assign w_len        = {bus.rx_byte, len_q[7:0]};

    boot_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK      (CLK),
        .reset    (reset),
        .clear_i  (w_to_clear),
        .en_i     (w_window),
        .expire_o (w_expire)
    );

    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_byte_d  = tx_byte_q;
        we_d       = 1'b0;
        // Address advances the cycle after the write pulse so WE sees the old one
        addr_d     = adv_q ? addr_q + 32'd4 : addr_q;
        wd_d       = wd_q;
        stall_d    = stall_q;
        cpu_rst_d  = 1'b0;
        err_d      = err_q;
        chk_d      = chk_q;
        bad_d      = bad_q;
        run_d      = run_q;
        adv_d      = 1'b0;
        cnt_d      = cnt_q;
        len_d      = len_q;

        if (w_sum_window && bus.rx_valid) begin
            chk_d = chk_q ^ bus.rx_byte;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid && bus.enable && (bus.rx_byte == SYNC_BYTE)) begin
                    state_d = ST_CMD;
                    stall_d = 1'b1;
                    chk_d   = 8'h00;
                    bad_d   = 1'b0;
                    run_d   = 1'b0;
                    cnt_d   = 2'd0;
                end
            end
            ST_CMD: begin
                if (bus.rx_valid) begin
                    cnt_d = 2'd0;
                    if (bus.rx_byte == CMD_WRITE) begin
                        state_d = ST_ADDR;
                    end else if (bus.rx_byte == CMD_RUN) begin
                        state_d = ST_CHK;
                        run_d   = 1'b1;
                    end else begin
                        state_d = ST_CHK;
                        bad_d   = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (bus.rx_valid) begin
                    addr_d[{cnt_q, 3'b000} +: 8] = bus.rx_byte;
                    cnt_d = cnt_q + 2'd1;
                    if ((cnt_q == 2'd0) && (bus.rx_byte[1:0] != 2'b00)) begin
                        bad_d = 1'b1;
                    end
                    if (cnt_q == 2'd3) begin
                        state_d = ST_LEN;
                    end
                end
            end
            ST_LEN: begin
                if (bus.rx_valid) begin
                    if (cnt_q == 2'd0) begin
                        len_d[7:0] = bus.rx_byte;
                        cnt_d      = 2'd1;
                    end else begin
                        cnt_d = 2'd0;
                        len_d = w_len;
                        if ((w_len == 16'd0) || (32'(w_len) > MAX_WORDS)) begin
                            bad_d   = 1'b1;
                            state_d = ST_CHK;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (bus.rx_valid) begin
                    wd_d[{cnt_q, 3'b000} +: 8] = bus.rx_byte;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        we_d  = !bad_q;
                        adv_d = 1'b1;
                        len_d = len_q - 16'd1;
                        if (len_q == 16'd1) begin
                            state_d = ST_CHK;
                        end
                    end
                end
            end
            ST_CHK: begin
                if (bus.rx_valid) begin
                    if (bad_q || (bus.rx_byte != chk_q)) begin
                        state_d    = ST_RESP;
                        tx_valid_d = 1'b1;
                        tx_byte_d  = NAK_BYTE;
                        err_d      = sat_inc8(err_q);
                    end else if (run_q) begin
                        state_d   = ST_RUN;
                        cpu_rst_d = 1'b1;
                        stall_d   = 1'b0;
                    end else begin
                        state_d    = ST_RESP;
                        tx_valid_d = 1'b1;
                        tx_byte_d  = ACK_BYTE;
                    end
                end
            end
            ST_RUN: begin
                state_d    = ST_RESP;
                tx_valid_d = 1'b1;
                tx_byte_d  = ACK_BYTE;
            end
            ST_RESP: begin
                if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abandoned packet: silent return to IDLE, stall left asserted
        if (w_expire) begin
            state_d = ST_IDLE;
            err_d   = sat_inc8(err_q);
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tx_valid_q <= 1'b0;
            tx_byte_q  <= 8'h00;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wd_q       <= 32'h0;
            stall_q    <= 1'b0;
            cpu_rst_q  <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 8'h00;
            chk_q      <= 8'h00;
            bad_q      <= 1'b0;
            run_q      <= 1'b0;
            adv_q      <= 1'b0;
            cnt_q      <= 2'd0;
            len_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_byte_q  <= tx_byte_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
            stall_q    <= stall_d;
            cpu_rst_q  <= cpu_rst_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            chk_q      <= chk_d;
            bad_q      <= bad_d;
            run_q      <= run_d;
            adv_q      <= adv_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
        end
    end

    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_byte   = tx_byte_q;
    assign bus.imem_WE   = we_q;
    assign bus.imem_A    = addr_q;
    assign bus.imem_WD   = wd_q;
    assign bus.cpu_stall = stall_q;
    assign bus.cpu_reset = cpu_rst_q;
    assign bus.busy      = busy_q;
    assign bus.err_count = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_boot_ctrl
// Description : Directed self-checking bench for uart_boot_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_boot_ctrl;

    typedef logic [7:0] byte_q_t[$];

    logic CLK;
    logic reset;
    uart_boot_ctrl_if bif ();

    int n_checks;
    int n_fail;

    logic [31:0] wa [0:63];
    logic [31:0] wd [0:63];
    int          we_cnt;

    uart_boot_ctrl #(
        .TIMEOUT_CYCLES (100),
        .MAX_WORDS      (1024)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        we_cnt = 0;
    end

    always @(negedge CLK) begin
        if (bif.imem_WE === 1'b1) begin
            wa[we_cnt[5:0]] = bif.imem_A;
            wd[we_cnt[5:0]] = bif.imem_WD;
            we_cnt = we_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bif.rx_valid = 1'b1;
        bif.rx_byte  = b;
        @(posedge CLK);
        #1;
        bif.rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input byte_q_t p);
        foreach (p[i]) send_byte(p[i]);
    endtask

    task automatic get_resp(output logic [7:0] b, output bit got);
        got = 1'b0;
        b   = 8'h00;
        for (int i = 0; i < 40; i++) begin
            if (bif.tx_valid === 1'b1 && bif.tx_ready === 1'b1) begin
                b   = bif.tx_byte;
                got = 1'b1;
                @(posedge CLK);
                #1;
                break;
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_cycles(3);
        reset = 1'b0;
        idle_cycles(1);
        n_checks++;
        if ({bif.tx_valid, bif.tx_byte, bif.imem_WE, bif.imem_A, bif.imem_WD,
             bif.cpu_stall, bif.cpu_reset} !== 76'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: actual tx_v=%b tx=%h we=%b a=%h wd=%h stall=%b crst=%b required all zero",
                     bif.tx_valid, bif.tx_byte, bif.imem_WE, bif.imem_A, bif.imem_WD,
                     bif.cpu_stall, bif.cpu_reset);
        end
        n_checks++;
        if (bif.busy !== 1'b0 || bif.err_count !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_busy_err: actual busy=%b err=%0d required busy=0 err=0",
                     bif.busy, bif.err_count);
        end
    endtask

    task automatic test_good_write();
        byte_q_t    p;
        logic [7:0] r;
        bit         got;
        int         base;
        base = we_cnt;
        p = {8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
             8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC2};
        send_pkt(p);
        get_resp(r, got);
        n_checks++;
        if (!got || r !== 8'h06) begin
            n_fail++;
            $display("FAIL good_write_resp: actual got=%b byte=%h required got=1 byte=06", got, r);
        end
        n_checks++;
        if (we_cnt - base !== 2) begin
            n_fail++;
            $display("FAIL good_write_count: actual %0d writes required 2", we_cnt - base);
        end
        n_checks++;
        if (wa[base[5:0]] !== 32'h0 || wd[base[5:0]] !== 32'h00500093) begin
            n_fail++;
            $display("FAIL good_write_w0: actual A=%h WD=%h required A=00000000 WD=00500093",
                     wa[base[5:0]], wd[base[5:0]]);
        end
        n_checks++;
        if (wa[base[5:0] + 6'd1] !== 32'h4 || wd[base[5:0] + 6'd1] !== 32'h00100113) begin
            n_fail++;
            $display("FAIL good_write_w1: actual A=%h WD=%h required A=00000004 WD=00100113",
                     wa[base[5:0] + 6'd1], wd[base[5:0] + 6'd1]);
        end
        n_checks++;
        if (bif.cpu_stall !== 1'b1 || bif.err_count !== 8'd0 || bif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL good_write_state: actual stall=%b err=%0d busy=%b required stall=1 err=0 busy=0",
                     bif.cpu_stall, bif.err_count, bif.busy);
        end
    endtask

    task automatic test_bad_chk();
        byte_q_t    p;
        logic [7:0] r;
        bit         got;
        int         base;
        base = we_cnt;
        p = {8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
             8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC3};
        send_pkt(p);
        get_resp(r, got);
        n_checks++;
        if (!got || r !== 8'h15) begin
            n_fail++;
            $display("FAIL bad_chk_resp: actual got=%b byte=%h required got=1 byte=15", got, r);
        end
        n_checks++;
        if (we_cnt - base !== 2 || wd[base[5:0] + 6'd1] !== 32'h00100113) begin
            n_fail++;
            $display("FAIL bad_chk_writes: actual %0d writes last WD=%h required 2 writes WD=00100113",
                     we_cnt - base, wd[base[5:0] + 6'd1]);
        end
        n_checks++;
        if (bif.err_count !== 8'd1 || bif.cpu_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_chk_err: actual err=%0d stall=%b required err=1 stall=1",
                     bif.err_count, bif.cpu_stall);
        end
    endtask

    task automatic test_bad_packets();
        byte_q_t    p;
        logic [7:0] r;
        bit         got;
        int         base;
        base = we_cnt;
        p = {8'hA5, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
        send_pkt(p);
        get_resp(r, got);
        n_checks++;
        if (!got || r !== 8'h15 || we_cnt != base) begin
            n_fail++;
            $display("FAIL misaligned_addr: actual got=%b byte=%h writes=%0d required byte=15 writes=0",
                     got, r, we_cnt - base);
        end
        n_checks++;
        if (bif.err_count !== 8'd2) begin
            n_fail++;
            $display("FAIL misaligned_err: actual err=%0d required 2", bif.err_count);
        end
        p = {8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        send_pkt(p);
        get_resp(r, got);
        n_checks++;
        if (!got || r !== 8'h15 || we_cnt != base) begin
            n_fail++;
            $display("FAIL len_zero: actual got=%b byte=%h writes=%0d required byte=15 writes=0",
                     got, r, we_cnt - base);
        end
        n_checks++;
        if (bif.err_count !== 8'd3) begin
            n_fail++;
            $display("FAIL len_zero_err: actual err=%0d required 3", bif.err_count);
        end
    endtask

    task automatic test_run_stall();
        byte_q_t p;
        bit      unstable;
        unstable = 1'b0;
        bif.tx_ready = 1'b0;
        p = {8'hA5, 8'h02, 8'h02};
        send_pkt(p);
        n_checks++;
        if (bif.cpu_reset !== 1'b1 || bif.cpu_stall !== 1'b0 || bif.tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL run_pulse: actual crst=%b stall=%b tx_v=%b required crst=1 stall=0 tx_v=0",
                     bif.cpu_reset, bif.cpu_stall, bif.tx_valid);
        end
        idle_cycles(1);
        n_checks++;
        if (bif.cpu_reset !== 1'b0 || bif.tx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL run_pulse_end: actual crst=%b tx_v=%b required crst=0 tx_v=1",
                     bif.cpu_reset, bif.tx_valid);
        end
        for (int i = 0; i < 10; i++) begin
            if (bif.tx_valid !== 1'b1 || bif.tx_byte !== 8'h06) unstable = 1'b1;
            idle_cycles(1);
        end
        n_checks++;
        if (unstable || bif.tx_valid !== 1'b1 || bif.tx_byte !== 8'h06) begin
            n_fail++;
            $display("FAIL run_hold: actual tx_v=%b tx=%h unstable=%b required tx_v=1 tx=06 stable",
                     bif.tx_valid, bif.tx_byte, unstable);
        end
        bif.tx_ready = 1'b1;
        idle_cycles(1);
        n_checks++;
        if (bif.tx_valid !== 1'b0 || bif.busy !== 1'b0 || bif.err_count !== 8'd3) begin
            n_fail++;
            $display("FAIL run_release: actual tx_v=%b busy=%b err=%0d required tx_v=0 busy=0 err=3",
                     bif.tx_valid, bif.busy, bif.err_count);
        end
    endtask

    task automatic test_timeout();
        byte_q_t    p;
        logic [7:0] r;
        bit         got;
        bit         saw_tx;
        saw_tx = 1'b0;
        p = {8'hA5, 8'h01};
        send_pkt(p);
        for (int i = 0; i < 99; i++) begin
            if (bif.tx_valid !== 1'b0) saw_tx = 1'b1;
            idle_cycles(1);
        end
        n_checks++;
        if (bif.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: actual busy=%b after 99 idle cycles required 1", bif.busy);
        end
        idle_cycles(1);
        n_checks++;
        if (bif.busy !== 1'b0 || bif.err_count !== 8'd4 || saw_tx || bif.tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_expire: actual busy=%b err=%0d tx_seen=%b required busy=0 err=4 no tx",
                     bif.busy, bif.err_count, saw_tx);
        end
        n_checks++;
        if (bif.cpu_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_stall: actual stall=%b required 1", bif.cpu_stall);
        end
        p = {8'hA5, 8'h02};
        send_pkt(p);
        idle_cycles(99);
        send_byte(8'h02);
        get_resp(r, got);
        n_checks++;
        if (!got || r !== 8'h06 || bif.err_count !== 8'd4 || bif.cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_edge_byte: actual got=%b byte=%h err=%0d stall=%b required byte=06 err=4 stall=0",
                     got, r, bif.err_count, bif.cpu_stall);
        end
    endtask

    task automatic test_reset_mid();
        byte_q_t    p;
        logic [7:0] r;
        bit         got;
        int         base;
        base = we_cnt;
        p = {8'hA5, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB};
        send_pkt(p);
        reset = 1'b1;
        idle_cycles(1);
        reset = 1'b0;
        n_checks++;
        if ({bif.tx_valid, bif.tx_byte, bif.imem_WE, bif.imem_A, bif.imem_WD,
             bif.cpu_stall, bif.cpu_reset, bif.busy, bif.err_count} !== 85'h0) begin
            n_fail++;
            $display("FAIL reset_mid: actual a=%h wd=%h stall=%b busy=%b err=%0d required all zero",
                     bif.imem_A, bif.imem_WD, bif.cpu_stall, bif.busy, bif.err_count);
        end
        p = {8'hA5, 8'h02, 8'h02};
        send_pkt(p);
        get_resp(r, got);
        n_checks++;
        if (!got || r !== 8'h06 || we_cnt != base) begin
            n_fail++;
            $display("FAIL reset_then_run: actual got=%b byte=%h writes=%0d required byte=06 writes=0",
                     got, r, we_cnt - base);
        end
        bif.enable = 1'b0;
        send_byte(8'hA5);
        n_checks++;
        if (bif.busy !== 1'b0 || bif.cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL disabled_sync: actual busy=%b stall=%b required busy=0 stall=0",
                     bif.busy, bif.cpu_stall);
        end
        send_byte(8'h02);
        send_byte(8'h02);
        idle_cycles(3);
        n_checks++;
        if (bif.busy !== 1'b0 || bif.tx_valid !== 1'b0 || bif.cpu_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL disabled_ignore: actual busy=%b tx_v=%b crst=%b required all 0",
                     bif.busy, bif.tx_valid, bif.cpu_reset);
        end
        bif.enable = 1'b1;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        bif.enable   = 1'b1;
        bif.rx_valid = 1'b0;
        bif.rx_byte  = 8'h00;
        bif.tx_ready = 1'b1;
        test_reset();
        test_good_write();
        test_bad_chk();
        test_bad_packets();
        test_run_stall();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
